// File: rtl/dec_onehot_scan.sv
// dec_onehot_scan: registered N-to-2^N one-hot decoder with direct-select and auto-scan modes
module dec_onehot_scan #(
    parameter int SEL_W      = 2,
    parameter int DWELL_W    = 16,
    parameter bit ACTIVE_LOW = 1'b0,
    localparam int OUT_W     = 2 ** SEL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel_in,
    input  logic               sel_valid,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT_W-1:0]   y,
    output logic [SEL_W-1:0]   cur_sel,
    output logic               wrap
);
    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
    localparam logic [OUT_W-1:0] INACTIVE = {OUT_W{ACTIVE_LOW}};
    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, cur_sel_q, cur_sel_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d, last_cnt;
    logic [OUT_W-1:0]   y_q, y_d;
    logic               wrap_q, wrap_d, scanning, step;

    // next state, scan stepping and the decoded value each output flop will take
    always_comb begin
        state_d   = !en ? IDLE : (mode ? SCAN : DIRECT);
        last_cnt  = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
        scanning  = (state_q == SCAN) && (state_d == SCAN);
        step      = scanning && (cnt_q >= last_cnt);
        cnt_d     = (scanning && !step) ? cnt_q + DWELL_W'(1) : '0;
        cur_sel_d = (state_d == IDLE)   ? cur_sel_q :
                    (state_d == DIRECT) ? sel_q :
                    !scanning           ? '0 :
                    step                ? cur_sel_q + SEL_W'(1) : cur_sel_q;
        wrap_d    = step && (&cur_sel_q);
        y_d       = (state_d == IDLE) ? INACTIVE : ((OUT_W'(1) << cur_sel_d) ^ INACTIVE);
    end

    // state, select latch, dwell counter and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            cur_sel_q <= '0;
            cnt_q     <= '0;
            y_q       <= INACTIVE;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_valid ? sel_in : sel_q;
            cur_sel_q <= cur_sel_d;
            cnt_q     <= cnt_d;
            y_q       <= y_d;
            wrap_q    <= wrap_d;
        end
    end

    assign y       = y_q;
    assign cur_sel = cur_sel_q;
    assign wrap    = wrap_q;
endmodule

// File: tb/tb_dec_onehot_scan.sv
// tb_dec_onehot_scan: scoreboard bench comparing three decoder configurations against a behavioural model
module tb_dec_onehot_scan;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0, en = 1'b0, mode = 1'b0, sel_valid = 1'b0;
    logic [2:0]  sel_in = '0;
    logic [15:0] dwell = '0;
    logic [3:0]  ya, yb;
    logic [7:0]  yc;
    logic [1:0]  ca, cb;
    logic [2:0]  cc;
    logic        wa, wb, wc;
    int          n_tests = 0, n_fail = 0;

    typedef struct {
        logic [3:0] y2, y2l;
        logic [1:0] c2;
        logic       w2;
        logic [7:0] y3;
        logic [2:0] c3;
        logic       w3;
    } exp_t;
    exp_t exp_q[$];

    // behavioural model state: what the outputs should show, not how the RTL stores it
    bit       m_scan = 0, m_active = 0, m_w2 = 0, m_w3 = 0;
    int       m_held = 0, m_pos2 = 0, m_pos3 = 0;
    bit [2:0] m_latch = 0;

    always #5 clk = ~clk;

    dec_onehot_scan #(.SEL_W(2), .ACTIVE_LOW(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in[1:0]),
        .sel_valid(sel_valid), .dwell(dwell), .y(ya), .cur_sel(ca), .wrap(wa));
    dec_onehot_scan #(.SEL_W(2), .ACTIVE_LOW(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in[1:0]),
        .sel_valid(sel_valid), .dwell(dwell), .y(yb), .cur_sel(cb), .wrap(wb));
    dec_onehot_scan #(.SEL_W(3), .ACTIVE_LOW(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in),
        .sel_valid(sel_valid), .dwell(dwell), .y(yc), .cur_sel(cc), .wrap(wc));

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // apply one cycle of inputs, advance the model to the next edge and queue the expectation
    task automatic drive(input bit r, input bit e, input bit m, input bit [2:0] s,
                         input bit v, input int d);
        exp_t x;
        int dd;
        rst_n = r; en = e; mode = m; sel_in = s; sel_valid = v; dwell = 16'(d);
        dd = (d == 0) ? 1 : d;
        m_w2 = 0; m_w3 = 0;
        if (!r) begin
            m_scan = 0; m_active = 0; m_pos2 = 0; m_pos3 = 0; m_held = 0; m_latch = 0;
        end else if (!e) begin
            m_scan = 0; m_active = 0;
        end else if (!m) begin
            m_scan = 0; m_active = 1; m_pos2 = int'(m_latch[1:0]); m_pos3 = int'(m_latch);
        end else if (!m_scan) begin
            m_scan = 1; m_active = 1; m_pos2 = 0; m_pos3 = 0; m_held = 1;
        end else if (m_held >= dd) begin
            m_pos2 = (m_pos2 + 1) % 4;
            m_pos3 = (m_pos3 + 1) % 8;
            m_held = 1;
            m_w2 = (m_pos2 == 0);
            m_w3 = (m_pos3 == 0);
        end else begin
            m_held++;
        end
        if (r && v) m_latch = s;
        x.y2 = '0; x.y3 = '0;
        if (m_active) begin
            x.y2[m_pos2] = 1'b1;
            x.y3[m_pos3] = 1'b1;
        end
        x.y2l = ~x.y2;
        x.c2 = 2'(m_pos2);
        x.c3 = 3'(m_pos3);
        x.w2 = m_w2;
        x.w3 = m_w3;
        exp_q.push_back(x);
        @(posedge clk);
        @(negedge clk);
    endtask

    // monitor: every registered output update is popped and compared
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (exp_q.size() != 0) begin
            x = exp_q.pop_front();
            chk("y_w2",       {4'h0, ya}, {4'h0, x.y2});
            chk("y_w2_al",    {4'h0, yb}, {4'h0, x.y2l});
            chk("cur_sel_w2", {6'h0, ca}, {6'h0, x.c2});
            chk("cur_sel_al", {6'h0, cb}, {6'h0, x.c2});
            chk("wrap_w2",    {7'h0, wa}, {7'h0, x.w2});
            chk("wrap_al",    {7'h0, wb}, {7'h0, x.w2});
            chk("y_w3",       yc,         x.y3);
            chk("cur_sel_w3", {5'h0, cc}, {5'h0, x.c3});
            chk("wrap_w3",    {7'h0, wc}, {7'h0, x.w3});
        end
    end

    initial begin
        bit r, e, m;
        repeat (2) drive(0, 1, 1, 3'd0, 0, 3);
        for (int i = 0; i < 4; i++) drive(1, 1, 0, 3'(i), 1, 3);
        repeat (3) drive(1, 1, 0, 3'd0, 0, 3);
        repeat (26) drive(1, 1, 1, 3'd0, 0, 3);
        repeat (10) drive(1, 1, 1, 3'd0, 0, 0);
        repeat (10) drive(1, 1, 1, 3'd0, 0, 1);
        drive(1, 0, 1, 3'd0, 0, 5);
        repeat (5) drive(1, 1, 1, 3'd0, 0, 5);
        repeat (6) drive(1, 1, 1, 3'd0, 0, 2);
        drive(1, 1, 1, 3'd2, 1, 3);
        repeat (3) drive(1, 1, 1, 3'd0, 0, 3);
        repeat (2) drive(1, 1, 0, 3'd0, 0, 3);
        repeat (4) drive(1, 1, 1, 3'd0, 0, 2);
        repeat (2) drive(1, 0, 1, 3'd0, 0, 2);
        repeat (4) drive(1, 1, 1, 3'd0, 0, 2);
        drive(0, 1, 1, 3'd3, 1, 2);
        drive(1, 1, 0, 3'd0, 0, 2);
        r = 1; e = 1; m = 1;
        repeat (2000) begin
            r = ($urandom_range(0, 49) != 0);
            e = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) m = ~m;
            drive(r, e, m, 3'($urandom_range(0, 7)), ($urandom_range(0, 9) < 3),
                  int'($urandom_range(0, 4)));
        end
        @(posedge clk);
        #2;
        chk("queue_drained", 8'(exp_q.size()), 8'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dec_onehot_scan.md
Name: dec_onehot_scan

Overview:
- Parametrised, registered N-to-2^N one-hot decoder. Generalises the basic 2-to-4 decoder to any select width.
- Adds an enable, a direct mode that latches a select value on a valid strobe, and an auto-scan mode that walks the active output through every position with a programmable dwell time.
- Used for digit/row strobing (7-seg anodes, keypad rows) and bank selection, between control logic and the I/O pins.

Parameters:
- SEL_W, 2, select width; the block has OUT_W = 2**SEL_W outputs. Legal range 1..6.
- DWELL_W, 16, width of the dwell-count input and the internal dwell counter.
- ACTIVE_LOW, 0, 0 = active output bit is 1; 1 = every output bit is inverted (active bit 0, inactive bits 1).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- en  in  1  block enable; 0 forces every output inactive.
- mode  in  1  0 = direct decode, 1 = auto-scan.
- sel_in  in  SEL_W  select value for direct mode.
- sel_valid  in  1  qualifies sel_in; sampled in every state.
- dwell  in  DWELL_W  cycles each scan position is held; 0 is treated as 1.
- y  out  OUT_W  registered one-hot decode output; polarity set by ACTIVE_LOW.
- cur_sel  out  SEL_W  index currently driven on y.
- wrap  out  1  one-cycle pulse when the scan returns to position 0.

Behaviour:
- The reset values below are the INACTIVE condition: y all inactive (0s, or 1s if ACTIVE_LOW=1), cur_sel=0, wrap=0, latched select=0, dwell counter=0, state=IDLE.
- States:
  - IDLE: y inactive, cur_sel frozen.
  - DIRECT: y decodes the latched select.
  - SCAN: y decodes the scan index.
- Transitions, evaluated every cycle, highest priority first:
  - en=0 -> IDLE.
  - en=1, mode=0 -> DIRECT.
  - en=1, mode=1 -> SCAN.
  - Outputs reflect the new state one cycle after the input change.
- Select latch:
  - sel_valid=1 at edge k loads sel_in into the latch in any state, including IDLE and SCAN.
  - In DIRECT, y and cur_sel show the new value at edge k+1. Fixed latency is 1 cycle from sel_valid to y.
  - Without sel_valid, y and cur_sel hold.
- Entering SCAN from IDLE or DIRECT:
  - Scan index is set to 0 and the dwell counter is cleared.
  - The first cycle in SCAN shows position 0. No wrap pulse is generated on entry.
- Scan stepping:
  - Let D = (dwell==0) ? 1 : dwell.
  - Each position is held for exactly D cycles. The counter increments each cycle; when it reaches D-1 it clears and the index advances by 1 on that edge.
  - dwell is sampled on every comparison, so a change takes effect within the current position. If the counter already exceeds the new D-1, the index advances on the next edge.
- Wrap:
  - Stepping from OUT_W-1 advances the index to 0 (modulo OUT_W).
  - wrap is asserted for exactly the first cycle in which y shows position 0 after a wrap.
- SCAN -> DIRECT: the next cycle shows the latched select. The scan index is not preserved; re-entering SCAN restarts at 0.
- Leaving SCAN mid-dwell, through en=0 or a mode change, abandons the count with no residual wrap pulse.
- y is always exactly one active bit in DIRECT and SCAN, and all-inactive in IDLE. No glitches: every output comes directly from a flop.
- rst_n=0 at any edge overrides all other inputs, including mid-scan and a simultaneous sel_valid. The cycle after reset shows reset values.

Test Plan:
- Reset: SEL_W=2, ACTIVE_LOW=0; drive rst_n=0 with en=1, mode=1 -> y=4'b0000, cur_sel=0, wrap=0 on the following cycle; repeat with ACTIVE_LOW=1 -> y=4'b1111.
- Direct decode: en=1, mode=0; pulse sel_valid with sel_in=0,1,2,3 on successive cycles -> y=0001,0010,0100,1000, each one cycle after its strobe; hold sel_valid=0 -> y holds 1000.
- Scan with dwell=3: enter SCAN -> y=0001 for 3 cycles, then 0010, 0100, 1000 for 3 cycles each, then 0001 again with wrap=1 for exactly 1 cycle; the period is 12 cycles.
- Boundary dwell: dwell=0 and dwell=1 -> the index advances every cycle and wrap pulses every 4 cycles. Change dwell from 5 to 2 while the counter is at 4 -> the index advances on the next edge.
- Mode and enable interplay:
  - Strobe sel_in=2 during SCAN -> y is unaffected.
  - Switch to mode=0 -> y=0100 on the next cycle.
  - Set en=0 mid-scan -> y=0000 on the next cycle, with no wrap pulse.
  - Set en=1, mode=1 -> the scan restarts at 0001.
- Width generality: SEL_W=3, dwell=1 -> y walks 8 one-hot positions, and wrap pulses every 8 cycles. Check on every cycle that y is one-hot, and that cur_sel always matches the index of the active bit.
